// File: rtl/i2c_slave_regfile_pkg.sv
// Shared I2C definitions: bit-engine state names, ACK/NACK levels and the
// default target address used by the register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Pad-side and write-notification signals of the register-file target.
// The slave modport is the target's view; the master modport is the bus side.
interface i2c_slave_regfile_if #(
  parameter int PTR_W = 4
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic             busy;
  logic             wr_stb;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, busy, wr_stb, wr_addr, wr_data
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, busy, wr_stb, wr_addr, wr_data
  );
endinterface

// File: rtl/i2c_slave_regfile_sync_edge.sv
// Two-flop synchronisers for SCL/SDA plus edge and START/STOP detection.
// Synchronisers reset to the idle bus level so reset never fakes an event.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl;

  // Synchronise both pads and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  assign start    = scl & scl_prev & sda_prev & ~sda;
  assign stop     = scl & scl_prev & ~sda_prev & sda;
endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a small 8-bit register file and auto-incrementing pointer.
// Everything runs on pclk; SCL/SDA are only oversampled.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = I2C_DEFAULT_ADDR,
  parameter int         NREG     = 16
) (
  input logic                pclk,
  input logic                preset,
  i2c_slave_regfile_if.slave bus
);
  localparam int PTR_W = $clog2(NREG);

  logic             sda, scl_rise, scl_fall, start, stop;
  i2c_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       rx_byte, rd_byte;
  logic [7:0]       regs [NREG];

  i2c_sync_edge u_sync (
    .clk      (pclk),
    .rst      (preset),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  // Protocol state, bit counter, shifter, pointer and registered outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file, written only by completed I2C data bytes.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (wr_stb_d) begin
      regs[wr_addr_d] <= wr_data_d;
    end
  end

  // Next-state logic: STOP/START override everything; SDA_OE otherwise moves on scl_fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rx_byte   = {shift_q[6:0], sda};
    rd_byte   = regs[ptr_q];

    if (stop) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              case (state_q)
                ADDR: if (rx_byte[7:1] != SLV_ADDR) state_d = IGNORE;
                PTR:  ptr_d = rx_byte[PTR_W-1:0];
                default: begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_byte;
                  ptr_d     = ptr_q + 1'b1;
                end
              endcase
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = '0;
            case (state_q)
              ADDR: begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end
              PTR:     state_d = PTR_ACK;
              default: state_d = WDATA_ACK;
            endcase
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q != ADDR_ACK) begin
              state_d = WDATA;
            end else if (shift_q[0]) begin
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 4'd1;
              state_d   = RDATA;
            end else begin
              state_d = PTR;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_NACK) begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end else begin
              bit_cnt_d = '0;
            end
          end else if (scl_fall && bit_cnt_q == 4'd0) begin
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 4'd1;
            state_d   = RDATA;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: a bit-banged I2C master drives the target while a
// transaction-level register model predicts ACKs, read data and write strobes.
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  localparam int         NREG = 16;
  localparam int         Q    = 50;
  localparam logic [6:0] SLV  = 7'h50;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic pclk        = 1'b0;
  logic preset      = 1'b1;
  logic scl         = 1'b1;
  logic sda_drv_low = 1'b0;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         wr_count = 0;
  bit         oe_seen = 0;
  logic [7:0] m_regs [NREG];
  int         m_ptr  = 0;
  bit         m_busy = 0;
  wr_t        exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [7:0] tx_q [$];

  i2c_slave_regfile_if #(.PTR_W(4)) bus ();

  assign bus.scl_in = scl;
  assign bus.sda_in = ~(sda_drv_low | bus.sda_oe);

  i2c_slave_regfile #(.SLV_ADDR(SLV), .NREG(NREG)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Shared comparison helper; every failure prints one FAIL line.
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the expected write whenever the target pulses wr_stb.
  always @(negedge pclk) begin : monitor
    wr_t e;
    if (bus.sda_oe === 1'b1) oe_seen = 1;
    if (bus.wr_stb === 1'b1) begin
      wr_count++;
      if (exp_wr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_write: actual addr %0d data 0x%0h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_wr.pop_front();
        check_output("wr_addr", 32'(bus.wr_addr), e.addr);
        check_output("wr_data", 32'(bus.wr_data), e.data);
      end
    end
  end

  task automatic send_bit(input logic b);
    sda_drv_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_drv_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = bus.sda_in;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda_drv_low = 1'b0;
      #Q scl = 1'b1;
      #Q;
    end
    sda_drv_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic stop_txn();
    sda_drv_low = 1'b1;
    #Q scl = 1'b1;
    #Q sda_drv_low = 1'b0;
    #(2*Q);
    m_busy = 0;
    check_output("busy_after_stop", 32'(bus.busy), 0);
    check_output("oe_after_stop", 32'(bus.sda_oe), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    check_output(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv_byte(input logic ack);
    logic [7:0] got;
    logic       b;
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      got[i] = b;
    end
    exp = exp_rd.pop_front();
    check_output("rd_data", 32'(got), 32'(exp));
    send_bit(ack);
  endtask

  // Write transaction: address byte then tx_q (pointer first, then data).
  task automatic apply_stimulus(input logic [6:0] addr, input bit do_stop);
    bit hit;
    hit = (addr == SLV);
    i2c_start();
    send_byte({addr, 1'b0}, hit ? I2C_ACK : I2C_NACK, "addr_ack");
    if (hit) m_busy = 1;
    check_output("busy_after_addr", 32'(bus.busy), 32'(m_busy));
    for (int i = 0; i < tx_q.size(); i++) begin
      if (hit) begin
        if (i == 0) begin
          m_ptr = tx_q[i] % NREG;
        end else begin
          m_regs[m_ptr] = tx_q[i];
          exp_wr.push_back('{addr: m_ptr, data: int'(tx_q[i])});
          m_ptr = (m_ptr + 1) % NREG;
        end
      end
      send_byte(tx_q[i], hit ? I2C_ACK : I2C_NACK, "data_ack");
    end
    if (do_stop) stop_txn();
  endtask

  // Read transaction of n bytes from the current pointer; last byte NACKed.
  task automatic read_txn(input int n, input bit do_stop);
    i2c_start();
    send_byte({SLV, 1'b1}, I2C_ACK, "rd_addr_ack");
    m_busy = 1;
    check_output("busy_in_read", 32'(bus.busy), 1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % NREG;
      recv_byte((i == n - 1) ? I2C_NACK : I2C_ACK);
    end
    check_output("oe_after_nack", 32'(bus.sda_oe), 0);
    if (do_stop) stop_txn();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wc0;
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;

    #40;
    check_output("rst_sda_oe", 32'(bus.sda_oe), 0);
    check_output("rst_busy", 32'(bus.busy), 0);
    check_output("rst_wr_stb", 32'(bus.wr_stb), 0);
    check_output("rst_wr_addr", 32'(bus.wr_addr), 0);
    check_output("rst_wr_data", 32'(bus.wr_data), 0);
    #3 preset = 1'b0;
    #7;

    $display("[TB] write 03: 5A C3");
    tx_q = '{8'h03, 8'h5A, 8'hC3};
    apply_stimulus(SLV, 1);

    $display("[TB] pointer 03, repeated start, read 2");
    tx_q = '{8'h03};
    apply_stimulus(SLV, 0);
    read_txn(2, 1);

    $display("[TB] foreign address 0x51");
    oe_seen = 0;
    wc0 = wr_count;
    tx_q = '{8'h01, 8'h02, 8'h03};
    apply_stimulus(7'h51, 1);
    check_output("foreign_oe_seen", 32'(oe_seen), 0);
    check_output("foreign_wr_count", wr_count, wc0);
    tx_q = '{8'h03};
    apply_stimulus(SLV, 0);
    read_txn(2, 1);

    $display("[TB] pointer wrap");
    tx_q = '{8'h0F, 8'h11, 8'h22};
    apply_stimulus(SLV, 1);
    tx_q = '{8'h0F};
    apply_stimulus(SLV, 0);
    read_txn(2, 1);

    $display("[TB] reset during address ACK");
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
    sda_drv_low = 1'b0;
    #Q scl = 1'b1;
    #Q;
    check_output("oe_during_ack", 32'(bus.sda_oe), 1);
    #3 preset = 1'b1;
    #1;
    check_output("oe_at_reset", 32'(bus.sda_oe), 0);
    check_output("busy_at_reset", 32'(bus.busy), 0);
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_ptr  = 0;
    m_busy = 0;
    #(Q-4) scl = 1'b0;
    #Q preset = 1'b0;
    #Q;
    stop_txn();
    read_txn(1, 1);

    $display("[TB] STOP inside a data byte");
    tx_q = '{8'h07};
    apply_stimulus(SLV, 0);
    wc0 = wr_count;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    stop_txn();
    check_output("partial_no_write", wr_count, wc0);
    tx_q = '{8'h05, 8'h77};
    apply_stimulus(SLV, 1);
    tx_q = '{8'h05};
    apply_stimulus(SLV, 0);
    read_txn(1, 1);

    $display("[TB] randomized transactions");
    repeat (25) begin
      int kind;
      int n;
      logic [6:0] addr;
      kind = $urandom_range(0, 3);
      tx_q = {};
      case (kind)
        0, 1: begin
          addr = ($urandom_range(0, 4) == 0) ? (SLV ^ 7'($urandom_range(1, 127))) : SLV;
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
          apply_stimulus(addr, 1);
        end
        2: begin
          tx_q.push_back(8'($urandom_range(0, 255)));
          apply_stimulus(SLV, 0);
          read_txn($urandom_range(1, 4), 1);
        end
        default: read_txn($urandom_range(1, 3), 1);
      endcase
    end

    #(4*Q);
    check_output("pending_writes", exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target that sits on the SDA/SCL bus downstream of the APB-controlled I2C master.
- Bench and system companion for that master: it answers a fixed 7-bit address and exposes a small 8-bit register file with an auto-incrementing pointer.
- Fully synchronous to PCLK; SCL and SDA are oversampled, never used as clocks.

Parameters:
- SLV_ADDR, 7'h50, 7-bit address this target acknowledges.
- NREG, 16, number of 8-bit registers; must be a power of 2.
- PTR_W, 4, pointer width, equal to log2(NREG); declared as a localparam derived from NREG.

Ports:
- PCLK  in  1  system clock; must be at least 8x the SCL rate.
- PRESET  in  1  asynchronous, active-high reset.
- SCL_IN  in  1  SCL pad input (asynchronous).
- SDA_IN  in  1  SDA pad input (asynchronous).
- SDA_OE  out  1  1 = pull SDA low (open-drain); 0 = release.
- BUSY  out  1  high from an addressed START until STOP.
- WR_STB  out  1  one-PCLK pulse per register write.
- WR_ADDR  out  PTR_W  register index being written.
- WR_DATA  out  8  data being written.

Behaviour:
- Reset: SDA_OE=0, BUSY=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, all registers=0, pointer=0, state IDLE, synchronisers=1.
- Input path: 2-flop synchroniser on each of SCL and SDA, plus a previous-value flop for edge detection.
  - scl_rise / scl_fall: edges of the synchronised SCL.
  - START: synchronised SDA falls while synchronised SCL is 1.
  - STOP: synchronised SDA rises while synchronised SCL is 1.
- Data sampling and driving:
  - Data bits are sampled on scl_rise, MSB first.
  - SDA_OE changes only on scl_fall, except on STOP/START: SDA_OE is forced to 0 in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE -> ADDR on START. START in any state -> ADDR (repeated START); the bit counter clears and the pointer is kept.
- ADDR: shift 8 bits. On the 8th scl_rise, compare bits[7:1] with SLV_ADDR.
  - Match: on the next scl_fall, SDA_OE=1 and go to ADDR_ACK; BUSY=1.
  - Mismatch: go to IGNORE and never drive.
- ADDR_ACK: on scl_fall, release SDA_OE.
  - R/W=0 -> PTR.
  - R/W=1 -> load regs[ptr] into the shift register, drive bit7 (SDA_OE = ~bit7) in that same scl_fall cycle, go to RDATA.
- PTR: shift 8 bits; ptr <= byte[PTR_W-1:0] (upper bits ignored); ACK exactly as in ADDR; PTR_ACK -> WDATA.
- WDATA: shift 8 bits.
  - After the 8th scl_rise: regs[ptr] <= byte; WR_STB pulses one cycle with WR_ADDR=ptr and WR_DATA=byte; ptr <= ptr+1 mod NREG (NREG-1 wraps to 0).
  - ACK, then WDATA_ACK -> WDATA.
- RDATA: on each scl_fall, drive the next bit.
  - After the 8th bit's scl_fall, SDA_OE=0 (released for the master's ACK); ptr <= ptr+1 mod NREG; go to RDATA_ACK.
- RDATA_ACK: sample SDA on scl_rise.
  - 0 (ACK): at the next scl_fall, load regs[ptr], drive bit7, go to RDATA.
  - 1 (NACK): IGNORE with SDA_OE=0.
- IGNORE: SDA_OE=0; wait for START or STOP.
- STOP in any state -> IDLE; SDA_OE=0, BUSY=0, pointer kept.
- Register writes come only from I2C; no external write port. Readback is through I2C only.
- PRESET mid-transfer: immediate return to the reset state; the bus is released the same cycle.

Decomposition:
- Package i2c_pkg holds the state enum (shared with the master's bit engine for naming consistency), the ACK/NACK constants, and the default target address.
- Sub-module i2c_sync_edge: 2-flop synchroniser plus START/STOP/scl_rise/scl_fall detection. It is reusable by the master's clock-stretch and arbitration logic.

Test Plan:
- Write [0xA0, 0x03, 0x5A, 0xC3] then STOP -> ACK on all 4 bytes; WR_STB pulses twice (addr 3=0x5A, addr 4=0xC3); BUSY falls after STOP.
- Write [0xA0, 0x03], repeated START, read [0xA1] with 2 bytes (ACK, then NACK) -> returns 0x5A, 0xC3; SDA released after the NACK.
- Address 0xA2 (7'h51) with 3 data bytes -> SDA_OE never asserted; no WR_STB; registers unchanged.
- Write pointer 0x0F then data 0x11, 0x22 -> reg15=0x11, reg0=0x22 (wrap).
- PRESET asserted while SDA_OE=1 during an ACK -> SDA_OE=0 in the same cycle; a later read from pointer 0 returns 0x00.
- STOP injected mid-byte during WDATA -> no WR_STB; state IDLE; the next START with 0xA0 is ACKed normally.
